veggie_lifecycle_ctrl: RTL
==========================

# veggie_lifecycle_ctrl

Frame-driven controller that sequences one veggie through spawn, flight, split and removal for the game display. It sits between the LFSR, the katana tracking coordinates and the veggie sprite renderers: it owns the top/bottom half positions and velocities, performs the per-frame katana hit test and emits split/gone/score events. All state changes happen only on the frame boundary, so sprites never tear mid-frame.

## Interface
- VEG_W, 128: veggie bounding-box width, pixels
- VEG_H, 128: veggie bounding-box height, pixels
- LAUNCH_VY, 20: upward launch speed, px/frame
- MAX_VY, 15: downward speed saturation, px/frame
- GRAV_DIV, 2: frames per +1 increment of vy
- SPAWN_DELAY, 30: frames spent in WAIT before each spawn
- SPLIT_DX, 2: horizontal separation speed added on split, px/frame
- FIXED_SPAWN_X, 448: spawn x used when random spawn is compiled out
- clk_in  input  1  pixel clock
- rst_in  input  1  asynchronous, active-low reset
- frame_done_in  input  1  one-cycle pulse at end of frame (hcount 1024, vcount 768)
- katana_x  input  11  katana x, screen pixels
- katana_y  input  10  katana y, screen pixels
- random_in  input  16  LFSR value, sampled at spawn
- top_x_out / bottom_x_out  output  11  half sprite x
- top_y_out / bottom_y_out  output  10  half sprite y (low 10 bits of internal y)
- visible_out  output  1  veggie drawn (FLYING or SPLIT and internal y ≥ 0)
- split_out  output  1  level: veggie currently split
- veggie_gone_out  output  1  one-cycle pulse on removal
- hit_pulse_out  output  1  one-cycle pulse on successful slice
- miss_pulse_out  output  1  one-cycle pulse when unsliced veggie exits bottom
- state_out  output  2  current state encoding

## Operation
- States: WAIT(0), FLYING(1), SPLIT(2), GONE(3). All transitions evaluated only on cycles with frame_done_in=1.
- WAIT: frame counter counts up; at SPAWN_DELAY-1 loads spawn: x = 128 + random_in[8:0], vx = random_in[11:9] − 4 (range −4..+3), y = 768 − VEG_H, vy = −LAUNCH_VY; both halves identical; counter cleared; → FLYING.
- FLYING/SPLIT, every frame: x += vx, y += vy (per half); gravity counter increments, at GRAV_DIV-1 wraps and vy += 1 saturating at +MAX_VY.
- Hit test (FLYING only, on pre-update position): x ≤ katana_x < x+VEG_W and y ≤ katana_y < y+VEG_H (signed compare, y may be negative) → SPLIT, hit_pulse_out, split_out=1; top vx −= SPLIT_DX, bottom vx += SPLIT_DX, top vy −= 2, bottom vy += 2 (bottom still saturated). Hit frame still applies motion with the new velocities.
- Exit: FLYING with vy>0 and y ≥ 768 → GONE with miss_pulse_out; SPLIT when both halves have vy>0 and y ≥ 768 → GONE.
- Hit and exit in same frame: hit wins; exit re-evaluated next frame.
- GONE: veggie_gone_out pulses, split_out cleared, → WAIT same frame.
- x arithmetic wraps modulo 2048; no horizontal clamping.
- Internal y signed 12 bits; internal vx, vy signed 7 bits.

## Timing
- All outputs registered; update one cycle after frame_done_in; positions constant across the frame.
- Pulses (veggie_gone_out, hit_pulse_out, miss_pulse_out) high for exactly one clk_in cycle.
- Reset (rst_in=0, any time, mid-flight included): state WAIT, counters 0, all positions 0, velocities 0, visible_out/split_out/all pulses 0; first spawn SPAWN_DELAY frames after release.
- frame_done_in held high multiple cycles is illegal; each high cycle counts as a frame.

## Configuration
- RANDOM_SPAWN_EN defined: spawn x and vx from random_in as above.
- Undefined: spawn x = FIXED_SPAWN_X, vx = 0; random_in ignored (port kept).

## Structure
- game_pkg: state enum, SCREEN_W=1024, SCREEN_H=768, coordinate/velocity widths, shared typedef for a half's {x, y, vx, vy}.
- Sub-module veggie_kinematics: one half's position/velocity integrator with gravity saturation and load/kick inputs; instantiated twice (top, bottom). Gravity counter shared in the controller.

## Test plan
- Reset release, 30 frames → spawn at y=640, vy=−20, FLYING; frame 31 y=620.
- RANDOM_SPAWN_EN, random_in=16'h0A05 → spawn x=133, vx=+1; undefined → x=448, vx=0.
- Katana held at veggie centre on frame 3 of flight → hit_pulse_out 1 cycle, split_out=1, top vx=vx−2, bottom vx=vx+2.
- No katana contact → vy saturates at 15, veggie reaches y≥768 → miss_pulse_out and veggie_gone_out same cycle, then WAIT.
- rst_in low mid-SPLIT → all outputs 0 immediately, asynchronous; respawn 30 frames after release.
- Hit on the same frame y crosses 768 → SPLIT taken, no miss pulse.

Source files
------------

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared screen geometry, widths, lifecycle states and per-half kinematic record
package game_pkg;
    localparam int SCREEN_W = 1024;
    localparam int SCREEN_H = 768;
    localparam int X_W      = 11;
    localparam int Y_W      = 12;
    localparam int V_W      = 7;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_FLYING = 2'd1,
        ST_SPLIT  = 2'd2,
        ST_GONE   = 2'd3
    } veg_state_e;

    typedef struct packed {
        logic        [X_W-1:0] x;
        logic signed [Y_W-1:0] y;
        logic signed [V_W-1:0] vx;
        logic signed [V_W-1:0] vy;
    } half_t;
endpackage

// File: rtl/veggie_lifecycle_ctrl_if.sv
// rtl/veggie_lifecycle_ctrl_if.sv - frame/katana/LFSR inputs and sprite/event outputs of the veggie controller
interface veggie_lifecycle_ctrl_if;
    import game_pkg::*;

    logic           frame_done_in;
    logic [X_W-1:0] katana_x;
    logic [9:0]     katana_y;
    logic [15:0]    random_in;
    logic [X_W-1:0] top_x_out;
    logic [X_W-1:0] bottom_x_out;
    logic [9:0]     top_y_out;
    logic [9:0]     bottom_y_out;
    logic           visible_out;
    logic           split_out;
    logic           veggie_gone_out;
    logic           hit_pulse_out;
    logic           miss_pulse_out;
    logic [1:0]     state_out;

    modport master (
        input  frame_done_in, katana_x, katana_y, random_in,
        output top_x_out, bottom_x_out, top_y_out, bottom_y_out, visible_out,
               split_out, veggie_gone_out, hit_pulse_out, miss_pulse_out, state_out
    );

    modport slave (
        output frame_done_in, katana_x, katana_y, random_in,
        input  top_x_out, bottom_x_out, top_y_out, bottom_y_out, visible_out,
               split_out, veggie_gone_out, hit_pulse_out, miss_pulse_out, state_out
    );
endinterface

// File: rtl/veggie_kinematics.sv
// rtl/veggie_kinematics.sv - one veggie half: position/velocity integrator with load, split kick and saturating gravity
module veggie_kinematics
    import game_pkg::*;
#(
    parameter int MAX_VY = 15
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  load_in,
    input  half_t                 load_val,
    input  logic                  step_in,
    input  logic                  kick_in,
    input  logic signed [V_W-1:0] kick_dvx,
    input  logic signed [V_W-1:0] kick_dvy,
    input  logic                  grav_tick_in,
    output logic        [X_W-1:0] x_out,
    output logic signed [Y_W-1:0] y_out,
    output logic signed [V_W-1:0] vy_out,
    output logic signed [Y_W-1:0] y_next
);
    localparam logic signed [V_W-1:0] VY_MAX   = V_W'(MAX_VY);
    localparam logic signed [V_W:0]   VY_MAX_W = (V_W+1)'(MAX_VY);

    half_t                 half_q;
    half_t                 half_d;
    logic signed [V_W:0]   vy_sum;
    logic signed [V_W-1:0] vx_k;
    logic signed [V_W-1:0] vy_k;
    logic signed [V_W-1:0] vy_g;

    // Motion on a kick frame uses the kicked velocities; gravity lands after the move.
    always_comb begin
        vy_sum = {half_q.vy[V_W-1], half_q.vy} + {kick_dvy[V_W-1], kick_dvy};
        vx_k   = half_q.vx;
        vy_k   = half_q.vy;
        if (kick_in) begin
            vx_k = half_q.vx + kick_dvx;
            vy_k = (vy_sum > VY_MAX_W) ? VY_MAX : vy_sum[V_W-1:0];
        end
        vy_g   = (grav_tick_in && (vy_k < VY_MAX)) ? vy_k + 7'sd1 : vy_k;
        half_d = half_q;
        if (load_in) begin
            half_d = load_val;
        end else if (step_in) begin
            half_d.x  = half_q.x + {{(X_W-V_W){vx_k[V_W-1]}}, vx_k};
            half_d.y  = half_q.y + {{(Y_W-V_W){vy_k[V_W-1]}}, vy_k};
            half_d.vx = vx_k;
            half_d.vy = vy_g;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            half_q <= '0;
        end else begin
            half_q <= half_d;
        end
    end

    assign x_out  = half_q.x;
    assign y_out  = half_q.y;
    assign vy_out = half_q.vy;
    assign y_next = half_d.y;
endmodule

// File: rtl/veggie_lifecycle_ctrl.sv
// rtl/veggie_lifecycle_ctrl.sv - veggie spawn/flight/split/removal sequencer stepped on frame boundaries
// RANDOM_SPAWN_EN: spawn x/vx taken from random_in; otherwise fixed x with zero vx.
module veggie_lifecycle_ctrl
    import game_pkg::*;
#(
    parameter int VEG_W         = 128,
    parameter int VEG_H         = 128,
    parameter int LAUNCH_VY     = 20,
    parameter int MAX_VY        = 15,
    parameter int GRAV_DIV      = 2,
    parameter int SPAWN_DELAY   = 30,
    parameter int SPLIT_DX      = 2,
    parameter int FIXED_SPAWN_X = 448
) (
    input  logic clk_in,
    input  logic rst_in,
    veggie_lifecycle_ctrl_if.master bus
);
    localparam int FC_W = $clog2(SPAWN_DELAY + 1);
    localparam int GC_W = $clog2(GRAV_DIV + 1);
    localparam logic signed [V_W-1:0] DX     = V_W'(SPLIT_DX);
    localparam logic signed [V_W-1:0] DVY    = 7'sd2;
    localparam logic signed [Y_W-1:0] EXIT_Y = Y_W'(SCREEN_H);

    veg_state_e            state_q, state_d;
    logic [FC_W-1:0]       frame_cnt_q, frame_cnt_d;
    logic [GC_W-1:0]       grav_cnt_q, grav_cnt_d;
    logic                  hit_q, miss_q, gone_q, split_q, visible_q;
    logic                  hit_d, miss_d, gone_d, visible_d;
    logic                  load, step, kick, grav_tick, hit, exit_top, exit_bot;
    half_t                 spawn;
    logic        [X_W-1:0] top_x, bot_x;
    logic signed [Y_W-1:0] top_y, bot_y, top_y_d, bot_y_d;
    logic signed [V_W-1:0] top_vy, bot_vy;
    logic        [X_W:0]   kx_w, x_w;
    logic signed [Y_W:0]   ky_s, y_s;
    logic                  unused_cfg;

    always_comb begin
        spawn.y  = Y_W'(SCREEN_H - VEG_H);
        spawn.vy = V_W'(-LAUNCH_VY);
`ifdef RANDOM_SPAWN_EN
        spawn.x  = X_W'(128) + {2'b00, bus.random_in[8:0]};
        spawn.vx = {4'b0000, bus.random_in[11:9]} - V_W'(4);
`else
        spawn.x  = X_W'(FIXED_SPAWN_X);
        spawn.vx = '0;
`endif
    end

`ifdef RANDOM_SPAWN_EN
    assign unused_cfg = ^{bus.random_in[15:12], X_W'(FIXED_SPAWN_X)};
`else
    assign unused_cfg = ^bus.random_in;
`endif

    veggie_kinematics #(.MAX_VY(MAX_VY)) u_top (
        .clk_in(clk_in), .rst_in(rst_in), .load_in(load), .load_val(spawn),
        .step_in(step), .kick_in(kick), .kick_dvx(-DX), .kick_dvy(-DVY),
        .grav_tick_in(grav_tick), .x_out(top_x), .y_out(top_y), .vy_out(top_vy), .y_next(top_y_d)
    );

    veggie_kinematics #(.MAX_VY(MAX_VY)) u_bottom (
        .clk_in(clk_in), .rst_in(rst_in), .load_in(load), .load_val(spawn),
        .step_in(step), .kick_in(kick), .kick_dvx(DX), .kick_dvy(DVY),
        .grav_tick_in(grav_tick), .x_out(bot_x), .y_out(bot_y), .vy_out(bot_vy), .y_next(bot_y_d)
    );

    // Hit box is tested on the pre-move position; x is widened so the box may extend past 2047.
    assign kx_w      = {1'b0, bus.katana_x};
    assign x_w       = {1'b0, top_x};
    assign ky_s      = {3'b000, bus.katana_y};
    assign y_s       = {top_y[Y_W-1], top_y};
    assign hit       = (x_w <= kx_w) && (kx_w < x_w + (X_W+1)'(VEG_W)) &&
                       (y_s <= ky_s) && (ky_s < y_s + (Y_W+1)'(VEG_H));
    assign exit_top  = (top_vy > 7'sd0) && (top_y >= EXIT_Y);
    assign exit_bot  = (bot_vy > 7'sd0) && (bot_y >= EXIT_Y);
    assign grav_tick = (grav_cnt_q == GC_W'(GRAV_DIV - 1));

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        grav_cnt_d  = grav_cnt_q;
        load        = 1'b0;
        step        = 1'b0;
        kick        = 1'b0;
        hit_d       = 1'b0;
        miss_d      = 1'b0;
        gone_d      = 1'b0;
        case (state_q)
            ST_WAIT: if (bus.frame_done_in) begin
                if (frame_cnt_q == FC_W'(SPAWN_DELAY - 1)) begin
                    load        = 1'b1;
                    frame_cnt_d = '0;
                    grav_cnt_d  = '0;
                    state_d     = ST_FLYING;
                end else begin
                    frame_cnt_d = frame_cnt_q + 1'b1;
                end
            end
            ST_FLYING, ST_SPLIT: if (bus.frame_done_in) begin
                step       = 1'b1;
                grav_cnt_d = grav_tick ? '0 : grav_cnt_q + 1'b1;
                if (state_q == ST_FLYING && hit) begin
                    kick    = 1'b1;
                    hit_d   = 1'b1;
                    state_d = ST_SPLIT;
                end else if (state_q == ST_FLYING && exit_top) begin
                    miss_d  = 1'b1;
                    gone_d  = 1'b1;
                    state_d = ST_GONE;
                end else if (state_q == ST_SPLIT && exit_top && exit_bot) begin
                    gone_d  = 1'b1;
                    state_d = ST_GONE;
                end
            end
            ST_GONE: begin
                state_d     = ST_WAIT;
                frame_cnt_d = '0;
            end
            default: state_d = ST_WAIT;
        endcase
        visible_d = ((state_d == ST_FLYING) || (state_d == ST_SPLIT)) &&
                    (!top_y_d[Y_W-1] || !bot_y_d[Y_W-1]);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= ST_WAIT;
            frame_cnt_q <= '0;
            grav_cnt_q  <= '0;
            hit_q       <= 1'b0;
            miss_q      <= 1'b0;
            gone_q      <= 1'b0;
            split_q     <= 1'b0;
            visible_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            grav_cnt_q  <= grav_cnt_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
            gone_q      <= gone_d;
            split_q     <= (state_d == ST_SPLIT);
            visible_q   <= visible_d;
        end
    end

    assign bus.top_x_out       = top_x;
    assign bus.bottom_x_out    = bot_x;
    assign bus.top_y_out       = top_y[9:0];
    assign bus.bottom_y_out    = bot_y[9:0];
    assign bus.visible_out     = visible_q;
    assign bus.split_out       = split_q;
    assign bus.veggie_gone_out = gone_q;
    assign bus.hit_pulse_out   = hit_q;
    assign bus.miss_pulse_out  = miss_q;
    assign bus.state_out       = state_q;
endmodule
